if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, >=2).
REQ-002 SHALL have parameter BUBBLE_INST, default 32'h0000_0013, instruction presented when no entry is valid (ADDI x0,x0,0).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port if_valid  input  1  fetch offers an entry this cycle.
REQ-006 SHALL have port if_inst  input  32  fetched instruction.
REQ-007 SHALL have port if_pc  input  32  PC of the fetched instruction.
REQ-008 SHALL have port if_branch_taken  input  1  fetch predicted branch taken.
REQ-009 SHALL have port if_branch_nt_pc  input  32  alternate (not-predicted) PC.
REQ-010 SHALL have port if_full  output  1  queue full; fetch holds its PC (feeds fetch interlock bubble).
REQ-011 SHALL have port id_ready  input  1  decode consumes head entry this cycle.
REQ-012 SHALL have port id_valid  output  1  head entry valid.
REQ-013 SHALL have ports id_inst/id_pc (output 32 each), id_branch_taken (output 1), id_branch_nt_pc (output 32): head entry fields.
REQ-014 SHALL have port ex_branch_flush  input  1  execute-stage mispredict flush.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-016 SHALL store entries as {inst, pc, branch_taken, branch_nt_pc} in a circular buffer with read pointer, write pointer and count registers.
REQ-017 SHALL push when if_valid=1, if_full=0, ex_branch_flush=0; entry written at write pointer, write pointer +1 modulo DEPTH.
REQ-018 SHALL pop when id_valid=1, id_ready=1, ex_branch_flush=0; read pointer +1 modulo DEPTH.
REQ-019 SHALL update count +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-020 SHALL drive if_full = (count==DEPTH) from registers only; a pop in the same cycle does not admit a push (no id_ready->if_full path).
REQ-021 SHALL drive id_valid = (count!=0) from registers only; id_* fields from entry at read pointer.
REQ-022 SHALL, when id_valid=0, drive id_inst=BUBBLE_INST, id_pc=0, id_branch_taken=0, id_branch_nt_pc=0.
REQ-023 SHALL give push-to-visible latency of one cycle: entry pushed at edge N appears at id_* after edge N when queue was empty.
REQ-024 SHALL, on ex_branch_flush=1 in a cycle, at the next edge set count=0 and read pointer = write pointer, discarding all entries and ignoring push and pop.
REQ-025 SHALL, during a cycle with ex_branch_flush=1, force id_valid=0 and id_inst=BUBBLE_INST combinationally.
REQ-026 SHALL ignore id_ready when id_valid=0 (pop from empty is no-op) and ignore if_valid when if_full=1 (fetch must hold).
REQ-027 SHALL preserve FIFO order across pointer wrap-around; pointers are $clog2(DEPTH) bits and wrap naturally.
REQ-028 SHALL never modify stored entry data except on push; entry storage needs no reset.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously set read pointer=0, write pointer=0, count=0, giving id_valid=0, if_full=0, id_inst=BUBBLE_INST, other id_* =0.
REQ-030 SHALL, on reset asserted mid-operation, discard all entries immediately; first push after rst_n rises behaves as on empty queue.

Verification
REQ-031 SHALL cover: push inst=32'h0040_0093 pc=0x100, id_ready=0 -> next cycle id_valid=1, id_inst=32'h0040_0093, id_pc=0x100, count=1.
REQ-032 SHALL cover: 4 pushes, id_ready=0, DEPTH=4 -> if_full=1, count=4; 5th if_valid ignored; then id_ready=1 pops in order pc 0x0,0x4,0x8,0xC.
REQ-033 SHALL cover: full queue, if_valid=1 and id_ready=1 same cycle -> pop only, count 4->3, if_full=0 next cycle.
REQ-034 SHALL cover: count=2, ex_branch_flush=1 with if_valid=1 -> same cycle id_inst=BUBBLE_INST, id_valid=0; next cycle count=0, pushed entry dropped.
REQ-035 SHALL cover: 10 continuous push/pop with id_ready=1 over pointer wrap -> outputs in exact push order, count steady at 1, branch_taken/nt_pc fields intact.
REQ-036 SHALL cover: rst_n driven low between edges with count=3 -> id_valid=0, count=0 immediately, no clock required.

Source files
------------

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular buffer of fetched entries with
// branch-prediction side data, mispredict flush and a bubble on empty.
module if_id_queue #(
   parameter int          DEPTH       = 4,
   parameter logic [31:0] BUBBLE_INST = 32'h0000_0013
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       if_valid,
   input  logic [31:0]                if_inst,
   input  logic [31:0]                if_pc,
   input  logic                       if_branch_taken,
   input  logic [31:0]                if_branch_nt_pc,
   output logic                       if_full,
   input  logic                       id_ready,
   output logic                       id_valid,
   output logic [31:0]                id_inst,
   output logic [31:0]                id_pc,
   output logic                       id_branch_taken,
   output logic [31:0]                id_branch_nt_pc,
   input  logic                       ex_branch_flush,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        branch_taken;
      logic [31:0] branch_nt_pc;
   } entry_t;

   entry_t          mem_r [DEPTH];
   logic [AW-1:0]   rd_ptr_r;
   logic [AW-1:0]   wr_ptr_r;
   logic [CW-1:0]   count_r;

   logic            full_s;
   logic            not_empty_s;
   logic            push_s;
   logic            pop_s;
   entry_t          wr_entry_s;
   entry_t          head_s;

   // Status comes only from registered count, so a same-cycle pop never frees a slot for fetch.
   assign full_s      = (count_r == CW'(DEPTH));
   assign not_empty_s = (count_r != {CW{1'b0}});
   assign push_s      = if_valid & ~full_s & ~ex_branch_flush;
   assign pop_s       = not_empty_s & id_ready & ~ex_branch_flush;

   assign wr_entry_s.inst         = if_inst;
   assign wr_entry_s.pc           = if_pc;
   assign wr_entry_s.branch_taken = if_branch_taken;
   assign wr_entry_s.branch_nt_pc = if_branch_nt_pc;

   assign head_s = mem_r[rd_ptr_r];

   // Pointer and occupancy state; flush collapses the queue onto the write pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (ex_branch_flush) begin
         rd_ptr_r <= wr_ptr_r;
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         if (push_s && !pop_s) begin
            count_r <= count_r + CW'(1);
         end else if (pop_s && !push_s) begin
            count_r <= count_r - CW'(1);
         end else begin
            count_r <= count_r;
         end
      end
   end

   // Entry storage is written only on push and carries no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_entry_s;
      end
   end

   // Head presentation: bubble whenever nothing valid or a flush is in progress.
   always_comb begin
      id_valid        = 1'b0;
      id_inst         = BUBBLE_INST;
      id_pc           = 32'h0000_0000;
      id_branch_taken = 1'b0;
      id_branch_nt_pc = 32'h0000_0000;
      if (not_empty_s && !ex_branch_flush) begin
         id_valid        = 1'b1;
         id_inst         = head_s.inst;
         id_pc           = head_s.pc;
         id_branch_taken = head_s.branch_taken;
         id_branch_nt_pc = head_s.branch_nt_pc;
      end else begin
         id_valid        = 1'b0;
      end
   end

   assign if_full = full_s;
   assign count   = count_r;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=4): reset, push/pop,
// full handling, flush, wrap-around streaming and asynchronous reset.
module tb_if_id_queue;

   localparam logic [31:0] BUBBLE = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic        if_branch_taken;
   logic [31:0] if_branch_nt_pc;
   logic        if_full;
   logic        id_ready;
   logic        id_valid;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic        id_branch_taken;
   logic [31:0] id_branch_nt_pc;
   logic        ex_branch_flush;
   logic [2:0]  count;

   int checks;
   int failures;

   if_id_queue #(.DEPTH(4), .BUBBLE_INST(32'h0000_0013)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
      .if_branch_taken(if_branch_taken), .if_branch_nt_pc(if_branch_nt_pc),
      .if_full(if_full), .id_ready(id_ready), .id_valid(id_valid),
      .id_inst(id_inst), .id_pc(id_pc), .id_branch_taken(id_branch_taken),
      .id_branch_nt_pc(id_branch_nt_pc), .ex_branch_flush(ex_branch_flush),
      .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_push(input logic [31:0] inst, input logic [31:0] pc,
                             input logic bt, input logic [31:0] nt);
      if_valid = 1'b1; if_inst = inst; if_pc = pc;
      if_branch_taken = bt; if_branch_nt_pc = nt;
   endtask

   task automatic idle();
      if_valid = 1'b0; id_ready = 1'b0; ex_branch_flush = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; idle();
      if_inst = 32'h0; if_pc = 32'h0; if_branch_taken = 1'b0; if_branch_nt_pc = 32'h0;
      #12;
      checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%0b exp=0", id_valid); end
      checks++; if (if_full !== 1'b0) begin failures++; $display("FAIL reset_if_full got=%0b exp=0", if_full); end
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (id_inst !== BUBBLE) begin failures++; $display("FAIL reset_id_inst got=%h exp=%h", id_inst, BUBBLE); end
      checks++; if (id_pc !== 32'h0 || id_branch_nt_pc !== 32'h0 || id_branch_taken !== 1'b0) begin
         failures++; $display("FAIL reset_id_fields pc=%h nt=%h bt=%0b exp=0", id_pc, id_branch_nt_pc, id_branch_taken); end
      @(negedge clk); rst_n = 1'b1;
      step();
   endtask

   task automatic test_single_push();
      drive_push(32'h0040_0093, 32'h0000_0100, 1'b1, 32'h0000_0200);
      step();
      idle();
      checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL single_id_valid got=%0b exp=1", id_valid); end
      checks++; if (id_inst !== 32'h0040_0093) begin failures++; $display("FAIL single_id_inst got=%h exp=00400093", id_inst); end
      checks++; if (id_pc !== 32'h0000_0100) begin failures++; $display("FAIL single_id_pc got=%h exp=00000100", id_pc); end
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
      checks++; if (id_branch_taken !== 1'b1 || id_branch_nt_pc !== 32'h0000_0200) begin
         failures++; $display("FAIL single_branch bt=%0b nt=%h exp bt=1 nt=00000200", id_branch_taken, id_branch_nt_pc); end
      id_ready = 1'b1;
      step();
      idle();
      checks++; if (count !== 3'd0 || id_valid !== 1'b0 || id_inst !== BUBBLE) begin
         failures++; $display("FAIL single_pop count=%0d valid=%0b inst=%h exp 0/0/%h", count, id_valid, id_inst, BUBBLE); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) begin
         drive_push(32'h0000_1000 + i, 32'(4 * i), 1'b0, 32'h0);
         step();
      end
      checks++; if (if_full !== 1'b1 || count !== 3'd4) begin
         failures++; $display("FAIL full_state if_full=%0b count=%0d exp 1/4", if_full, count); end
      drive_push(32'h0000_1004, 32'h0000_0010, 1'b0, 32'h0);
      step();
      checks++; if (count !== 3'd4 || id_pc !== 32'h0) begin
         failures++; $display("FAIL full_fifth_ignored count=%0d head_pc=%h exp 4/0", count, id_pc); end
      // Push and pop together on a full queue: only the pop takes effect.
      id_ready = 1'b1;
      step();
      checks++; if (count !== 3'd3 || if_full !== 1'b0) begin
         failures++; $display("FAIL full_pop_only count=%0d if_full=%0b exp 3/0", count, if_full); end
      if_valid = 1'b0;
      for (int i = 1; i < 4; i++) begin
         checks++; if (id_pc !== 32'(4 * i) || id_inst !== 32'h0000_1000 + i) begin
            failures++; $display("FAIL full_order[%0d] pc=%h inst=%h exp pc=%h", i, id_pc, id_inst, 4 * i); end
         step();
      end
      idle();
      checks++; if (count !== 3'd0 || id_valid !== 1'b0) begin
         failures++; $display("FAIL full_drained count=%0d valid=%0b exp 0/0", count, id_valid); end
   endtask

   task automatic test_flush();
      drive_push(32'h0000_2000, 32'h0000_0200, 1'b0, 32'h0); step();
      drive_push(32'h0000_2001, 32'h0000_0204, 1'b0, 32'h0); step();
      idle();
      checks++; if (count !== 3'd2) begin failures++; $display("FAIL flush_setup count=%0d exp 2", count); end
      drive_push(32'h0000_2002, 32'h0000_0208, 1'b0, 32'h0);
      id_ready = 1'b1; ex_branch_flush = 1'b1;
      #1;
      checks++; if (id_valid !== 1'b0 || id_inst !== BUBBLE) begin
         failures++; $display("FAIL flush_comb valid=%0b inst=%h exp 0/%h", id_valid, id_inst, BUBBLE); end
      step();
      idle();
      checks++; if (count !== 3'd0 || id_valid !== 1'b0) begin
         failures++; $display("FAIL flush_next count=%0d valid=%0b exp 0/0", count, id_valid); end
      drive_push(32'h0000_3000, 32'h0000_0300, 1'b1, 32'h0000_0400); step();
      idle();
      checks++; if (count !== 3'd1 || id_pc !== 32'h0000_0300 || id_inst !== 32'h0000_3000) begin
         failures++; $display("FAIL flush_repush count=%0d pc=%h inst=%h exp 1/00000300/00003000", count, id_pc, id_inst); end
      id_ready = 1'b1; step(); idle();
   endtask

   task automatic test_back_to_back();
      drive_push(32'h0000_0093, 32'h0000_1000, 1'b0, 32'h0000_2000);
      step();
      for (int k = 0; k < 10; k++) begin
         drive_push(32'h0000_0093 | (32'(k + 1) << 20), 32'h0000_1000 + 32'(4 * (k + 1)),
                    1'((k + 1) & 1), 32'h0000_2000 + 32'(8 * (k + 1)));
         id_ready = 1'b1;
         #1;
         checks++; if (id_inst !== (32'h0000_0093 | (32'(k) << 20)) || id_pc !== 32'h0000_1000 + 32'(4 * k) ||
                       id_branch_taken !== 1'(k & 1) || id_branch_nt_pc !== 32'h0000_2000 + 32'(8 * k)) begin
            failures++; $display("FAIL stream_head[%0d] inst=%h pc=%h bt=%0b nt=%h", k, id_inst, id_pc, id_branch_taken, id_branch_nt_pc); end
         step();
         checks++; if (count !== 3'd1) begin failures++; $display("FAIL stream_count[%0d] got=%0d exp 1", k, count); end
      end
      if_valid = 1'b0;
      checks++; if (id_pc !== 32'h0000_1028 || id_branch_taken !== 1'b0 || id_branch_nt_pc !== 32'h0000_2050) begin
         failures++; $display("FAIL stream_last pc=%h bt=%0b nt=%h exp 00001028/0/00002050", id_pc, id_branch_taken, id_branch_nt_pc); end
      step();
      idle();
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL stream_drain count=%0d exp 0", count); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         drive_push(32'h0000_4000 + i, 32'h0000_0500 + 32'(4 * i), 1'b0, 32'h0);
         step();
      end
      idle();
      checks++; if (count !== 3'd3) begin failures++; $display("FAIL areset_setup count=%0d exp 3", count); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (id_valid !== 1'b0 || count !== 3'd0 || id_inst !== BUBBLE || id_pc !== 32'h0) begin
         failures++; $display("FAIL areset_immediate valid=%0b count=%0d inst=%h pc=%h", id_valid, count, id_inst, id_pc); end
      @(negedge clk); rst_n = 1'b1;
      step();
      drive_push(32'h0000_5000, 32'h0000_0600, 1'b0, 32'h0);
      step();
      idle();
      checks++; if (count !== 3'd1 || id_pc !== 32'h0000_0600 || id_inst !== 32'h0000_5000) begin
         failures++; $display("FAIL areset_repush count=%0d pc=%h inst=%h exp 1/00000600/00005000", count, id_pc, id_inst); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_single_push();
      test_full();
      test_flush();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
